// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: conditions raw pins, frames bytes, assembles 3-byte movement packets into ps2_mouse.
// Latency: stop-bit strobe on cycle N -> byte valid/byte_err on N+1, ps2_mouse and first-byte sync_err on N+2.
// Backpressure: none; the producer owns the ps2_mouse word, and a new packet toggles bit 24.
// Optional build macro PS2_MOUSE_RX_PARITY_CHECK_EN: when defined, odd parity is checked in the stop state.
module ps2_mouse_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 57000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [24:0] ps2_mouse,
  output logic        byte_err,
  output logic        sync_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Input conditioning state
  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          clk_filt_q, clk_filt_d;
  logic          data_filt_q, data_filt_d;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d;
  logic [FW-1:0] data_cnt_q, data_cnt_d;
  logic          clk_prev_q, clk_prev_d;
  logic          strobe;

  // Framing and packet state
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_vld_q, byte_vld_d;
  logic          byte_err_q, byte_err_d;
  logic          sync_err_q, sync_err_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [7:0]    byte1_q, byte1_d;
  logic [24:0]   mouse_q, mouse_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_ok;

`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
  logic          parity_q, parity_d;
  // Odd parity: data bits plus parity bit must contain an odd number of ones
  assign frame_ok = data_filt_q & (^{shift_q, parity_q});
`else
  // Parity bit is consumed by the framing FSM but not stored or checked
  assign frame_ok = data_filt_q;
`endif

  // Synchronise both pins and debounce them with saturating run-length filters
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
    clk_filt_d  = clk_filt_q;
    data_filt_d = data_filt_q;
    clk_cnt_d   = '0;
    data_cnt_d  = '0;
    clk_prev_d  = clk_filt_q;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_cnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
      else                                  clk_cnt_d  = clk_cnt_q + FW'(1);
    end
    if (data_sync_q[1] != data_filt_q) begin
      if (data_cnt_q == FW'(FILTER_LEN - 1)) data_filt_d = data_sync_q[1];
      else                                   data_cnt_d  = data_cnt_q + FW'(1);
    end
  end

  // Sample strobe is the first cycle the filtered clock reads low
  assign strobe = clk_prev_q & ~clk_filt_q;

  // Next-state logic for bit framing, packet assembly, timeout and enable
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    byte_err_d = 1'b0;
    sync_err_d = 1'b0;
    idx_d      = idx_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    mouse_d    = mouse_q;
    to_cnt_d   = to_cnt_q;
`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
    parity_d   = parity_q;
`endif

    // Packet assembly runs one cycle behind the stop strobe; the shift
    // register is stable then because the next start bit is far away.
    if (byte_vld_q) begin
      case (idx_q)
        2'd0: begin
          if (!shift_q[3]) begin
            sync_err_d = 1'b1;
          end else begin
            byte0_d = shift_q;
            idx_d   = 2'd1;
          end
        end
        2'd1: begin
          byte1_d = shift_q;
          idx_d   = 2'd2;
        end
        default: begin
          mouse_d = {~mouse_q[24], shift_q, byte1_q, byte0_q};
          idx_d   = 2'd0;
        end
      endcase
    end

    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_filt_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_filt_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
          parity_d = data_filt_q;
`endif
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (frame_ok) begin
            byte_vld_d = 1'b1;
          end else begin
            byte_err_d = 1'b1;
            idx_d      = 2'd0;
          end
        end
      endcase
    end

    // Every strobe clears the counter, so a timeout can never coincide with
    // a framing error; the error path always owns that cycle.
    if (strobe || (state_q == ST_IDLE && idx_q == 2'd0)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      to_cnt_d   = TW'(TIMEOUT_CYCLES);
      state_d    = ST_IDLE;
      idx_d      = 2'd0;
      sync_err_d = 1'b1;
    end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    // Disabled: hold the receiver idle, keep the last packet, stay silent
    if (!enable) begin
      state_d    = ST_IDLE;
      idx_d      = 2'd0;
      to_cnt_d   = '0;
      byte_vld_d = 1'b0;
      byte_err_d = 1'b0;
      sync_err_d = 1'b0;
      mouse_d    = mouse_q;
    end
  end

  // Conditioning registers; idle PS/2 lines are high
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_cnt_q   <= '0;
      data_cnt_q  <= '0;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_cnt_q   <= clk_cnt_d;
      data_cnt_q  <= data_cnt_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  // Framing FSM, packet assembler and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      byte_err_q <= 1'b0;
      sync_err_q <= 1'b0;
      idx_q      <= '0;
      byte0_q    <= '0;
      byte1_q    <= '0;
      mouse_q    <= '0;
      to_cnt_q   <= '0;
`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
      byte_err_q <= byte_err_d;
      sync_err_q <= sync_err_d;
      idx_q      <= idx_d;
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      mouse_q    <= mouse_d;
      to_cnt_q   <= to_cnt_d;
`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign ps2_mouse = mouse_q;
  assign byte_err  = byte_err_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: drives PS/2 frames on the raw pins and checks packets and error pulses.
// Latency: checks the two-cycle stop-strobe-to-ps2_mouse timing on the first packet.
// Backpressure: none; error pulses are counted by a monitor sampling on the falling clock edge.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;
  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 37;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        ps2_clk_i = 1'b1;
  logic        ps2_data_i = 1'b1;
  logic [24:0] ps2_mouse;
  logic        byte_err;
  logic        sync_err;

  int errors = 0;
  int checks = 0;
  int be_cnt = 0;
  int se_cnt = 0;

  ps2_mouse_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .enable    (enable),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_mouse (ps2_mouse),
    .byte_err  (byte_err),
    .sync_err  (sync_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Count high cycles of each error output; a 1-cycle pulse counts once
  always @(negedge clk_sys) begin
    if (byte_err === 1'b1) be_cnt = be_cnt + 1;
    if (sync_err === 1'b1) se_cnt = se_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    enable     = 1'b1;
    ps2_clk_i  = 1'b1;
    ps2_data_i = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    be_cnt = 0;
    se_cnt = 0;
  endtask

  task automatic ps2_fall(input logic d);
    ps2_data_i = d;
    tick(HALF);
    ps2_clk_i = 1'b0;
  endtask

  task automatic ps2_rise();
    tick(HALF);
    ps2_clk_i = 1'b1;
  endtask

  // Send the first nbits of an 11-bit frame: start, 8 data LSB first, odd parity, stop
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int nbits);
    logic [10:0] frame;
    frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_fall(frame[i]);
      ps2_rise();
    end
    ps2_data_i = 1'b1;
    tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b0, 11);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ps2_mouse !== 25'h0) begin
      $display("FAIL reset_mouse: got %h expected %h", ps2_mouse, 25'h0);
      errors++;
    end
    checks++;
    if (byte_err !== 1'b0 || sync_err !== 1'b0) begin
      $display("FAIL reset_errs: got byte_err=%b sync_err=%b expected 0 0", byte_err, sync_err);
      errors++;
    end
  endtask

  task automatic test_good_packet();
    do_reset();
    send_byte(8'h09);
    send_byte(8'h05);
    send_bits(8'hFB, 1'b0, 1'b0, 10);
    ps2_fall(1'b1);
    // Stop-bit strobe lands FL+2 cycles after the raw fall; update is 2 cycles later
    tick(FL + 3);
    checks++;
    if (ps2_mouse !== 25'h0) begin
      $display("FAIL good_early: got %h expected %h", ps2_mouse, 25'h0);
      errors++;
    end
    tick(1);
    checks++;
    if (ps2_mouse !== {1'b1, 8'hFB, 8'h05, 8'h09}) begin
      $display("FAIL good_update: got %h expected %h", ps2_mouse, {1'b1, 8'hFB, 8'h05, 8'h09});
      errors++;
    end
    tick(HALF - FL - 4);
    ps2_clk_i = 1'b1;
    tick(HALF);
    checks++;
    if (be_cnt !== 0 || se_cnt !== 0) begin
      $display("FAIL good_errs: got byte_err=%0d sync_err=%0d expected 0 0", be_cnt, se_cnt);
      errors++;
    end
  endtask

  task automatic test_resync();
    do_reset();
    send_byte(8'h01);
    send_packet(8'h08, 8'h00, 8'h00);
    checks++;
    if (se_cnt !== 1) begin
      $display("FAIL resync_sync_err: got %0d expected 1", se_cnt);
      errors++;
    end
    checks++;
    if (ps2_mouse !== {1'b1, 8'h00, 8'h00, 8'h08}) begin
      $display("FAIL resync_mouse: got %h expected %h", ps2_mouse, {1'b1, 8'h00, 8'h00, 8'h08});
      errors++;
    end
  endtask

  task automatic test_bad_parity();
    do_reset();
    send_byte(8'h18);
    send_bits(8'h22, 1'b1, 1'b0, 11);
    send_byte(8'h33);
`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
    checks++;
    if (be_cnt !== 1) begin
      $display("FAIL parity_byte_err: got %0d expected 1", be_cnt);
      errors++;
    end
    checks++;
    if (ps2_mouse !== 25'h0) begin
      $display("FAIL parity_dropped: got %h expected %h", ps2_mouse, 25'h0);
      errors++;
    end
    send_packet(8'h28, 8'h01, 8'h02);
    checks++;
    if (ps2_mouse !== {1'b1, 8'h02, 8'h01, 8'h28}) begin
      $display("FAIL parity_recover: got %h expected %h", ps2_mouse, {1'b1, 8'h02, 8'h01, 8'h28});
      errors++;
    end
`else
    checks++;
    if (be_cnt !== 0) begin
      $display("FAIL parity_byte_err: got %0d expected 0", be_cnt);
      errors++;
    end
    checks++;
    if (ps2_mouse !== {1'b1, 8'h33, 8'h22, 8'h18}) begin
      $display("FAIL parity_accept: got %h expected %h", ps2_mouse, {1'b1, 8'h33, 8'h22, 8'h18});
      errors++;
    end
`endif
  endtask

  task automatic test_bad_stop();
    do_reset();
    send_byte(8'h08);
    send_bits(8'h44, 1'b0, 1'b1, 11);
    checks++;
    if (be_cnt !== 1) begin
      $display("FAIL stop_byte_err: got %0d expected 1", be_cnt);
      errors++;
    end
    send_packet(8'h0A, 8'h11, 8'h22);
    checks++;
    if (ps2_mouse !== {1'b1, 8'h22, 8'h11, 8'h0A}) begin
      $display("FAIL stop_recover: got %h expected %h", ps2_mouse, {1'b1, 8'h22, 8'h11, 8'h0A});
      errors++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    send_byte(8'h08);
    send_bits(8'h55, 1'b0, 1'b0, 5);
    tick(TO + 10);
    checks++;
    if (se_cnt !== 1 || be_cnt !== 0) begin
      $display("FAIL stall_timeout: got sync_err=%0d byte_err=%0d expected 1 0", se_cnt, be_cnt);
      errors++;
    end
    send_packet(8'h0C, 8'h10, 8'h20);
    checks++;
    if (ps2_mouse !== {1'b1, 8'h20, 8'h10, 8'h0C}) begin
      $display("FAIL stall_recover: got %h expected %h", ps2_mouse, {1'b1, 8'h20, 8'h10, 8'h0C});
      errors++;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    ps2_data_i = 1'b0;
    tick(20);
    ps2_clk_i = 1'b0;
    tick(FL - 1);
    ps2_clk_i = 1'b1;
    tick(20);
    ps2_data_i = 1'b1;
    tick(40);
    send_packet(8'h09, 8'h00, 8'h01);
    checks++;
    if (ps2_mouse !== {1'b1, 8'h01, 8'h00, 8'h09}) begin
      $display("FAIL glitch_packet: got %h expected %h", ps2_mouse, {1'b1, 8'h01, 8'h00, 8'h09});
      errors++;
    end
    checks++;
    if (be_cnt !== 0 || se_cnt !== 0) begin
      $display("FAIL glitch_errs: got byte_err=%0d sync_err=%0d expected 0 0", be_cnt, se_cnt);
      errors++;
    end
  endtask

  task automatic test_enable();
    do_reset();
    send_byte(8'h08);
    enable = 1'b0;
    tick(10);
    send_byte(8'h08);
    enable = 1'b1;
    tick(10);
    send_packet(8'h19, 8'h7F, 8'h80);
    checks++;
    if (ps2_mouse !== {1'b1, 8'h80, 8'h7F, 8'h19}) begin
      $display("FAIL enable_packet: got %h expected %h", ps2_mouse, {1'b1, 8'h80, 8'h7F, 8'h19});
      errors++;
    end
    checks++;
    if (be_cnt !== 0 || se_cnt !== 0) begin
      $display("FAIL enable_errs: got byte_err=%0d sync_err=%0d expected 0 0", be_cnt, se_cnt);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_packet(8'h08, 8'h01, 8'h02);
    checks++;
    if (ps2_mouse !== {1'b1, 8'h02, 8'h01, 8'h08}) begin
      $display("FAIL b2b_first: got %h expected %h", ps2_mouse, {1'b1, 8'h02, 8'h01, 8'h08});
      errors++;
    end
    send_packet(8'h29, 8'h03, 8'h04);
    checks++;
    if (ps2_mouse !== {1'b0, 8'h04, 8'h03, 8'h29}) begin
      $display("FAIL b2b_second: got %h expected %h", ps2_mouse, {1'b0, 8'h04, 8'h03, 8'h29});
      errors++;
    end
  endtask

  task automatic test_reset_mid_byte();
    do_reset();
    send_packet(8'h38, 8'h12, 8'h34);
    send_byte(8'h08);
    send_bits(8'h0F, 1'b0, 1'b0, 4);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ps2_mouse !== 25'h0 || byte_err !== 1'b0 || sync_err !== 1'b0) begin
      $display("FAIL reset_mid: got mouse=%h byte_err=%b sync_err=%b expected 0 0 0", ps2_mouse, byte_err, sync_err);
      errors++;
    end
    tick(3);
    reset_n = 1'b1;
    ps2_data_i = 1'b1;
    tick(3);
    se_cnt = 0;
    be_cnt = 0;
    send_packet(8'h0B, 8'h21, 8'h43);
    checks++;
    if (ps2_mouse !== {1'b1, 8'h43, 8'h21, 8'h0B}) begin
      $display("FAIL reset_recover: got %h expected %h", ps2_mouse, {1'b1, 8'h43, 8'h21, 8'h0B});
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_resync();
    test_bad_parity();
    test_bad_stop();
    test_stall();
    test_glitch();
    test_enable();
    test_back_to_back();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
